arm_mem_arbiter: RTL

//  Shares one unified memory port between the ARM core's instruction-fetch and data (load/store) requesters.

---
 rtl/arm_mem_pkg.sv | 15 +
 rtl/arm_mem_arbiter_if.sv | 34 +++
 rtl/arb_pick2.sv | 29 ++
 rtl/arm_mem_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state and transaction owner.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/arm_mem_arbiter_if.sv
// Bundle of core-side (fetch/data) and memory-side signals around the arbiter.
interface arm_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ack;

  // Arbiter view: serves the core requesters and drives the memory port.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ack,
    output i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, m_be
  );

  // Environment view: the core requesters plus the memory model.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way picker between fetch and data requests.
module arb_pick2
  import arm_mem_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b0
) (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t rr_last,
  output owner_t grant
);

  always_comb begin
    grant = OWN_FETCH;
    if (d_req && !i_req) begin
      grant = OWN_DATA;
    end else if (d_req && i_req) begin
      // On a tie, round-robin hands the port to whoever did not win last time.
      if (PRIO_DATA) begin
        grant = OWN_DATA;
      end else if (rr_last == OWN_FETCH) begin
        grant = OWN_DATA;
      end else begin
        grant = OWN_FETCH;
      end
    end
  end

endmodule

// File: rtl/arm_mem_arbiter.sv
// Shares one memory port between instruction fetch and data accesses,
// one transaction at a time, with a timeout abort for hung memory.
module arm_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b0,
  parameter int TIMEOUT   = 16,
  parameter int TO_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  arm_mem_arbiter_if.slave bus
);

  arb_state_t      state_reg;
  arb_state_t      state_next;
  owner_t          owner_reg;
  owner_t          rr_last_reg;
  owner_t          grant;
  logic [TO_W-1:0] cnt_reg;
  logic            err_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     wdata_reg;
  logic            we_reg;
  logic [1:0]      be_reg;
  logic            any_req;
  logic            timeout_hit;
  logic            finish;
  logic [31:0]     rdata_vec [2];
  logic [1:0]      ack_vec;

  assign any_req     = bus.i_req | bus.d_req;
  assign timeout_hit = (cnt_reg == TO_W'(TIMEOUT - 1));
  assign finish      = (state_reg == BUSY) && (bus.m_ack || timeout_hit);

  arb_pick2 #(.PRIO_DATA(PRIO_DATA)) u_pick (
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
    .rr_last (rr_last_reg),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (finish)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched only at grant so the memory side stays stable in BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg   <= OWN_FETCH;
      rr_last_reg <= OWN_FETCH;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      be_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (any_req) begin
            owner_reg   <= grant;
            rr_last_reg <= grant;
            if (grant == OWN_DATA) begin
              addr_reg  <= bus.d_addr;
              wdata_reg <= bus.d_wdata;
              we_reg    <= bus.d_we;
              be_reg    <= bus.d_be;
            end else begin
              addr_reg  <= bus.i_addr;
              wdata_reg <= '0;
              we_reg    <= 1'b0;
              be_reg    <= 2'b00;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (timeout_hit && !bus.m_ack) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
          cnt_reg <= '0;
          err_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester read-data capture and completion pulse; index 0 is fetch, 1 is data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg <= '0;
      end else if (finish && (owner_reg == owner_t'(gi))) begin
        rdata_reg <= bus.m_ack ? bus.m_rdata : 32'h0;
      end
    end

    assign rdata_vec[gi] = rdata_reg;
    assign ack_vec[gi]   = (state_reg == DONE) && (owner_reg == owner_t'(gi));
  end

  always_comb begin
    bus.m_req   = (state_reg == BUSY);
    bus.m_we    = we_reg;
    bus.m_addr  = addr_reg;
    bus.m_wdata = wdata_reg;
    bus.m_be    = be_reg;
    bus.i_ack   = ack_vec[0];
    bus.d_ack   = ack_vec[1];
    bus.i_rdata = rdata_vec[0];
    bus.d_rdata = rdata_vec[1];
    bus.err     = (state_reg == DONE) && err_reg;
  end

endmodule
